// File: rtl/regfile_writeback_arbiter.sv
// Write-port sequencer for the 32-entry register file.
// Two writeback requesters share the single write port under round-robin
// arbitration. A busy scoreboard tracks the destinations that have writes in
// flight so the issue stage can stall on RAW/WAW hazards.
module regfile_writeback_arbiter #(
   parameter int unsigned ADDR_BUS_WIDTH = 5,
   parameter int unsigned DATA_BUS_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req0_valid,
   input  logic [ADDR_BUS_WIDTH-1:0] req0_addr,
   input  logic [DATA_BUS_WIDTH-1:0] req0_data,
   output logic                      req0_ready,
   input  logic                      req1_valid,
   input  logic [ADDR_BUS_WIDTH-1:0] req1_addr,
   input  logic [DATA_BUS_WIDTH-1:0] req1_data,
   output logic                      req1_ready,
   input  logic                      issue_valid,
   input  logic [ADDR_BUS_WIDTH-1:0] issue_addr,
   output logic                      issue_ready,
   input  logic [ADDR_BUS_WIDTH-1:0] query_addr1,
   input  logic [ADDR_BUS_WIDTH-1:0] query_addr2,
   output logic                      busy1,
   output logic                      busy2,
   output logic [ADDR_BUS_WIDTH-1:0] rf_addr,
   output logic [DATA_BUS_WIDTH-1:0] rf_data,
   output logic                      rf_write_en,
   output logic                      wb_unexpected
);

   localparam int unsigned NUM_REGS = 1 << ADDR_BUS_WIDTH;

   typedef enum logic {
      GRANT_REQ0 = 1'b0,
      GRANT_REQ1 = 1'b1
   } grant_e;

   grant_e                    last_grant_q, last_grant_d;
   logic [NUM_REGS-1:0]       busy_q, busy_d;
   logic [ADDR_BUS_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_BUS_WIDTH-1:0] rf_data_q, rf_data_d;
   logic                      rf_write_en_q, rf_write_en_d;
   logic                      wb_unexpected_q, wb_unexpected_d;

   logic                      grant0, grant1;
   logic                      wb_fire;
   logic [ADDR_BUS_WIDTH-1:0] wb_addr;
   logic [DATA_BUS_WIDTH-1:0] wb_data;
   logic                      issue_fire;
   logic                      same_edge_set;

   // Round-robin grant: a tie goes to the requester that did not win last.
   // Grants are held low while reset is asserted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset_n) begin
         if (req0_valid && req1_valid) begin
            if (last_grant_q == GRANT_REQ1) begin
               grant0 = 1'b1;
            end else begin
               grant1 = 1'b1;
            end
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   // Winner select and scoreboard reservation qualification.
   always_comb begin
      wb_fire       = grant0 | grant1;
      wb_addr       = grant1 ? req1_addr : req0_addr;
      wb_data       = grant1 ? req1_data : req0_data;
      issue_fire    = reset_n && issue_valid && !busy_q[issue_addr];
      same_edge_set = issue_fire && (issue_addr == wb_addr);
   end

   // Next-state: scoreboard set/clear, write-port load, arbiter history.
   always_comb begin
      busy_d          = busy_q;
      rf_addr_d       = rf_addr_q;
      rf_data_d       = rf_data_q;
      rf_write_en_d   = 1'b0;
      last_grant_d    = last_grant_q;
      wb_unexpected_d = wb_unexpected_q;

      if (wb_fire) begin
         rf_addr_d     = wb_addr;
         rf_data_d     = wb_data;
         rf_write_en_d = (wb_addr != '0);
         last_grant_d  = grant1 ? GRANT_REQ1 : GRANT_REQ0;
         busy_d[wb_addr] = 1'b0;
         if ((wb_addr != '0) && !busy_q[wb_addr] && !same_edge_set) begin
            wb_unexpected_d = 1'b1;
         end
      end

      // Applied after the clear so a same-edge reservation keeps the register busy.
      if (issue_fire) begin
         busy_d[issue_addr] = 1'b1;
      end

      busy_d[0] = 1'b0;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q    <= GRANT_REQ1;
         busy_q          <= '0;
         rf_addr_q       <= '0;
         rf_data_q       <= '0;
         rf_write_en_q   <= 1'b0;
         wb_unexpected_q <= 1'b0;
      end else begin
         last_grant_q    <= last_grant_d;
         busy_q          <= busy_d;
         rf_addr_q       <= rf_addr_d;
         rf_data_q       <= rf_data_d;
         rf_write_en_q   <= rf_write_en_d;
         wb_unexpected_q <= wb_unexpected_d;
      end
   end

   // Output drive.
   always_comb begin
      req0_ready    = grant0;
      req1_ready    = grant1;
      issue_ready   = issue_fire;
      busy1         = busy_q[query_addr1];
      busy2         = busy_q[query_addr2];
      rf_addr       = rf_addr_q;
      rf_data       = rf_data_q;
      rf_write_en   = rf_write_en_q;
      wb_unexpected = wb_unexpected_q;
   end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed stimulus, a per-cycle
// behavioural model comparison, and literal expectations at key points.
module tb_regfile_writeback_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        issue_ready;
   logic [4:0]  query_addr1, query_addr2;
   logic        busy1, busy2;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        rf_write_en;
   logic        wb_unexpected;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_writeback_arbiter #(
      .ADDR_BUS_WIDTH(5),
      .DATA_BUS_WIDTH(32)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .query_addr1(query_addr1), .query_addr2(query_addr2), .busy1(busy1), .busy2(busy2),
      .rf_addr(rf_addr), .rf_data(rf_data), .rf_write_en(rf_write_en), .wb_unexpected(wb_unexpected)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_busy[32];
   int          m_last;          // index of requester granted most recently
   logic [4:0]  m_rf_addr;
   logic [31:0] m_rf_data;
   bit          m_we;
   bit          m_unexp;

   bit          n_busy[32];
   int          n_last;
   logic [4:0]  n_rf_addr;
   logic [31:0] n_rf_data;
   bit          n_we;
   bit          n_unexp;

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last    = 1;
      m_rf_addr = '0;
      m_rf_data = '0;
      m_we      = 1'b0;
      m_unexp   = 1'b0;
   endtask

   initial model_reset();
   always @(negedge reset_n) model_reset();

   // Compare on every negedge, then commit the model at the following posedge.
   always begin
      bit e_r0, e_r1, e_iss;
      int winner;
      logic [4:0]  w_addr;
      logic [31:0] w_data;
      @(negedge clk);
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (reset_n) begin
         if (req0_valid && req1_valid) begin
            winner = 1 - m_last;
            e_r0 = (winner == 0);
            e_r1 = (winner == 1);
         end else begin
            e_r0 = req0_valid;
            e_r1 = req1_valid;
         end
      end
      e_iss = reset_n && issue_valid && !m_busy[issue_addr];

      check("m_req0_ready", {31'b0, req0_ready}, {31'b0, e_r0});
      check("m_req1_ready", {31'b0, req1_ready}, {31'b0, e_r1});
      check("m_issue_ready", {31'b0, issue_ready}, {31'b0, e_iss});
      check("m_busy1", {31'b0, busy1}, {31'b0, m_busy[query_addr1]});
      check("m_busy2", {31'b0, busy2}, {31'b0, m_busy[query_addr2]});
      check("m_rf_write_en", {31'b0, rf_write_en}, {31'b0, m_we});
      check("m_rf_addr", {27'b0, rf_addr}, {27'b0, m_rf_addr});
      check("m_rf_data", rf_data, m_rf_data);
      check("m_wb_unexpected", {31'b0, wb_unexpected}, {31'b0, m_unexp});

      n_busy    = m_busy;
      n_last    = m_last;
      n_rf_addr = m_rf_addr;
      n_rf_data = m_rf_data;
      n_we      = 1'b0;
      n_unexp   = m_unexp;
      if (e_r0 || e_r1) begin
         w_addr    = e_r1 ? req1_addr : req0_addr;
         w_data    = e_r1 ? req1_data : req0_data;
         n_last    = e_r1 ? 1 : 0;
         n_rf_addr = w_addr;
         n_rf_data = w_data;
         n_we      = (w_addr != 0);
         if (w_addr != 0 && !m_busy[w_addr] && !(e_iss && issue_addr == w_addr))
            n_unexp = 1'b1;
         n_busy[w_addr] = 1'b0;
      end
      if (e_iss && issue_addr != 0) n_busy[issue_addr] = 1'b1;

      @(posedge clk);
      if (reset_n) begin
         m_busy    = n_busy;
         m_last    = n_last;
         m_rf_addr = n_rf_addr;
         m_rf_data = n_rf_data;
         m_we      = n_we;
         m_unexp   = n_unexp;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0; issue_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1;
      idle_inputs();
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      issue_addr = '0; query_addr1 = '0; query_addr2 = '0;
      #1 reset_n = 1'b0;

      // Reset with both requesters valid.
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h6;
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h2004;
      query_addr1 = 5'd9; query_addr2 = 5'd5;
      cyc();
      @(negedge clk);
      check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
      check("rst_rf_write_en", {31'b0, rf_write_en}, 32'd0);
      check("rst_busy1", {31'b0, busy1}, 32'd0);
      cyc();
      reset_n = 1'b1;

      // Round-robin over four tie cycles: grants 0,1,0,1.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            check("rr_req0_ready", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_req1_ready", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         end
         if (i > 0) begin
            check("rr_rf_addr", {27'b0, rf_addr}, (i % 2 == 1) ? 32'd5 : 32'd9);
            check("rr_rf_data", rf_data, (i % 2 == 1) ? 32'h6 : 32'h2004);
            check("rr_rf_write_en", {31'b0, rf_write_en}, 32'd1);
         end
         cyc();
         if (i == 3) idle_inputs();
      end
      check("rr_wb_unexpected", {31'b0, wb_unexpected}, 32'd1);

      // Fresh reset before the scoreboard tests.
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;

      // RAW: reserve 9, then requester 1 writes it.
      issue_valid = 1'b1; issue_addr = 5'd9; query_addr1 = 5'd9;
      @(negedge clk);
      check("raw_issue_ready", {31'b0, issue_ready}, 32'd1);
      check("raw_busy1_pre", {31'b0, busy1}, 32'd0);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk);
      check("raw_busy1_set", {31'b0, busy1}, 32'd1);
      cyc();
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h2004;
      @(negedge clk);
      check("raw_req1_ready", {31'b0, req1_ready}, 32'd1);
      cyc();
      req1_valid = 1'b0;
      @(negedge clk);
      check("raw_busy1_clr", {31'b0, busy1}, 32'd0);
      check("raw_rf_write_en", {31'b0, rf_write_en}, 32'd1);
      check("raw_rf_addr", {27'b0, rf_addr}, 32'd9);
      check("raw_rf_data", rf_data, 32'h2004);
      check("raw_wb_unexpected", {31'b0, wb_unexpected}, 32'd0);
      cyc();

      // WAW: reserve 5, second issue to 5 stalls until its writeback.
      issue_valid = 1'b1; issue_addr = 5'd5; query_addr2 = 5'd5;
      cyc();
      @(negedge clk);
      check("waw_stall0", {31'b0, issue_ready}, 32'd0);
      check("waw_busy2", {31'b0, busy2}, 32'd1);
      cyc();
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAA;
      @(negedge clk);
      check("waw_stall1", {31'b0, issue_ready}, 32'd0);
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      check("waw_busy2_clr", {31'b0, busy2}, 32'd0);
      check("waw_issue_ready", {31'b0, issue_ready}, 32'd1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk);
      check("waw_busy2_reset", {31'b0, busy2}, 32'd1);
      cyc();

      // Same-edge reserve and writeback of 12: reservation survives.
      issue_valid = 1'b1; issue_addr = 5'd12;
      req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h12;
      query_addr1 = 5'd12;
      @(negedge clk);
      check("sw_issue_ready", {31'b0, issue_ready}, 32'd1);
      check("sw_req0_ready", {31'b0, req0_ready}, 32'd1);
      cyc();
      idle_inputs();
      @(negedge clk);
      check("sw_busy1", {31'b0, busy1}, 32'd1);
      check("sw_wb_unexpected", {31'b0, wb_unexpected}, 32'd0);
      check("sw_rf_addr", {27'b0, rf_addr}, 32'd12);
      cyc();

      // Register 0: consumed, never enabled, never reserved.
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_addr = 5'd0; query_addr1 = 5'd0;
      @(negedge clk);
      check("r0_req0_ready", {31'b0, req0_ready}, 32'd1);
      check("r0_issue_ready", {31'b0, issue_ready}, 32'd1);
      cyc();
      idle_inputs();
      @(negedge clk);
      check("r0_rf_write_en", {31'b0, rf_write_en}, 32'd0);
      check("r0_busy1", {31'b0, busy1}, 32'd0);
      check("r0_wb_unexpected", {31'b0, wb_unexpected}, 32'd0);
      cyc();

      // Unexpected writeback to 7, then asynchronous reset mid-cycle.
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
      cyc();
      idle_inputs();
      @(negedge clk);
      check("ux_wb_unexpected", {31'b0, wb_unexpected}, 32'd1);
      check("ux_rf_write_en", {31'b0, rf_write_en}, 32'd1);
      check("ux_rf_addr", {27'b0, rf_addr}, 32'd7);
      #2 reset_n = 1'b0;
      #1;
      check("ar_rf_write_en", {31'b0, rf_write_en}, 32'd0);
      check("ar_wb_unexpected", {31'b0, wb_unexpected}, 32'd0);
      check("ar_busy2", {31'b0, busy2}, 32'd0);
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
